// File: rtl/mem_access.sv
`timescale 1ns/1ps
// Memory-access pipeline stage: issues loads/stores over a req/ack data port,
// extracts and extends load lanes, flags misaligned accesses, and builds the MEM->WB bus.
module mem_access (
  input  logic         clk,
  input  logic         reset,
  input  logic         MEM_valid,
  input  logic [159:0] EXE_MEM_bus_r,
  input  logic         WB_allow_in,
  input  logic         cancel,
  output logic         dm_req,
  output logic         dm_wr,
  output logic [31:0]  dm_addr,
  output logic [3:0]   dm_wstrb,
  output logic [31:0]  dm_wdata,
  input  logic         dm_ack,
  input  logic [31:0]  dm_rdata,
  output logic         MEM_over,
  output logic [156:0] MEM_WB_bus,
  output logic [4:0]   MEM_wdest,
  output logic [31:0]  MEM_pc
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  typedef struct packed {
    logic        is_load;
    logic        is_store;
    logic [1:0]  size;
    logic        load_unsigned;
    logic [31:0] store_data;
    logic        wen;
    logic [4:0]  wdest;
    logic [31:0] exe_result;
    logic [31:0] lo_result;
    logic        hi_write;
    logic        lo_write;
    logic        mfhi;
    logic        mflo;
    logic        mtc0;
    logic        mfc0;
    logic [7:0]  cp0r_addr;
    logic        syscall;
    logic        eret;
    logic        brk;
    logic        fetch_error;
    logic        inst_reserved;
    logic        overflow;
    logic        delay_slot;
    logic [31:0] pc;
  } exe_bus_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        is_load;
    logic [1:0]  size;
    logic        load_unsigned;
  } req_t;

  exe_bus_t    ex;
  logic [1:0]  state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  req_t        req_q, req_now, req_act;
  logic        mem_op, misalign, prior_exc, issue, in_idle, load_cap;
  logic        raddr_error, waddr_error;
  logic [31:0] lane, load_ext, mem_result;

  assign ex        = EXE_MEM_bus_r;
  assign in_idle   = (state_q == S_IDLE);
  assign mem_op    = ex.is_load | ex.is_store;
  assign misalign  = ((ex.size == 2'b01) & ex.exe_result[0]) |
                     ((ex.size == 2'b10) & (ex.exe_result[1:0] != 2'b00));
  assign prior_exc = ex.fetch_error | ex.inst_reserved | ex.overflow | ex.syscall | ex.brk;
  assign issue     = MEM_valid & mem_op & ~misalign & ~prior_exc & ~cancel;

  // NOTE: every signal written in always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    req_now               = '0;
    req_now.wr            = ex.is_store;
    req_now.addr          = ex.exe_result;
    req_now.is_load       = ex.is_load;
    req_now.size          = ex.size;
    req_now.load_unsigned = ex.load_unsigned;
    req_now.wstrb         = 4'b1111;
    req_now.wdata         = ex.store_data;
    case (ex.size)
      2'b00: begin
        req_now.wstrb = 4'b0001 << ex.exe_result[1:0];
        req_now.wdata = {4{ex.store_data[7:0]}};
      end
      2'b01: begin
        req_now.wstrb = ex.exe_result[1] ? 4'b1100 : 4'b0011;
        req_now.wdata = {2{ex.store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Request fields come straight from the bus in the issue cycle, then from the
  // captured copy so they stay stable even if the bus is flushed mid-request.
  assign req_act = in_idle ? req_now : req_q;

  always_comb begin
    lane     = dm_rdata >> {req_act.addr[1:0], 3'b000};
    load_ext = dm_rdata;
    case (req_act.size)
      2'b00:   load_ext = {{24{~req_act.load_unsigned & lane[7]}}, lane[7:0]};
      2'b01:   load_ext = {{16{~req_act.load_unsigned & lane[15]}}, lane[15:0]};
      default: ;
    endcase
  end

  assign load_cap = dm_ack & req_act.is_load & ((in_idle & issue) | (state_q == S_WAIT));
  assign rdata_d  = load_cap ? load_ext : rdata_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (issue) state_d = dm_ack ? S_HOLD : S_WAIT;
      S_WAIT: begin
        if (cancel)      state_d = dm_ack ? S_IDLE : S_DRAIN;
        else if (dm_ack) state_d = S_HOLD;
      end
      S_HOLD:  if (cancel || WB_allow_in) state_d = S_IDLE;
      S_DRAIN: if (dm_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  // NOTE: req_q is a pure datapath capture; it is only observed while dm_req is high, so it needs no reset.
  always_ff @(posedge clk) begin
    if (in_idle && issue) req_q <= req_now;
  end

  assign dm_req   = ~reset & ((in_idle & issue) | (state_q == S_WAIT) | (state_q == S_DRAIN));
  assign dm_wr    = req_act.wr;
  assign dm_addr  = req_act.addr;
  assign dm_wstrb = req_act.wstrb;
  assign dm_wdata = req_act.wdata;

  assign MEM_over = ~reset & (in_idle ? (MEM_valid & ~issue & ~cancel)
                                      : ((state_q == S_HOLD) & ~cancel));

  assign mem_result  = ((state_q == S_HOLD) & ex.is_load) ? rdata_q : ex.exe_result;
  assign raddr_error = ex.is_load  & misalign & ~prior_exc;
  assign waddr_error = ex.is_store & misalign & ~prior_exc;

  assign MEM_WB_bus = {ex.wen, ex.wdest, mem_result, ex.lo_result,
                       ex.hi_write, ex.lo_write, ex.mfhi, ex.mflo, ex.mtc0, ex.mfc0,
                       ex.cp0r_addr, ex.syscall, ex.eret, ex.brk, ex.fetch_error,
                       ex.inst_reserved, raddr_error, waddr_error, ex.overflow,
                       ex.exe_result, ex.delay_slot, ex.pc};

  assign MEM_wdest = ex.wdest & {5{MEM_valid}};
  assign MEM_pc    = ex.pc;

endmodule

// File: tb/tb_mem_access.sv
`timescale 1ns/1ps
// Self-checking bench for mem_access: random instructions against a word-array
// memory model with a scoreboard on the MEM->WB transfer, plus directed corner cases.
module tb_mem_access;

  logic         clk = 1'b0;
  logic         reset, MEM_valid, WB_allow_in, cancel;
  logic [159:0] EXE_MEM_bus_r;
  logic         dm_req, dm_wr, dm_ack, MEM_over;
  logic [31:0]  dm_addr, dm_wdata, dm_rdata, MEM_pc;
  logic [3:0]   dm_wstrb;
  logic [156:0] MEM_WB_bus;
  logic [4:0]   MEM_wdest;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .reset(reset), .MEM_valid(MEM_valid), .EXE_MEM_bus_r(EXE_MEM_bus_r),
    .WB_allow_in(WB_allow_in), .cancel(cancel),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wstrb(dm_wstrb),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .MEM_over(MEM_over), .MEM_WB_bus(MEM_WB_bus), .MEM_wdest(MEM_wdest), .MEM_pc(MEM_pc)
  );

  typedef struct {
    bit          is_load, is_store;
    bit [1:0]    size;
    bit          lu;
    logic [31:0] sdata;
    bit          wen;
    bit [4:0]    wdest;
    logic [31:0] exe, lo;
    bit [5:0]    f6;
    bit [7:0]    cp0;
    bit          sys, eret, brk, ferr, ires, ovf, ds;
    logic [31:0] pc;
  } instr_t;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [31:0]  mem [16];
  logic [156:0] sb_q [$];
  bit           exp_wr;
  logic [31:0]  exp_addr, exp_wdata;
  logic [3:0]   exp_wstrb;
  int           force_lat = -1;
  int           last_lat  = 0;
  int           lat       = 0;
  bit           busy      = 1'b0;
  bit           last_wr;
  logic [3:0]   last_wstrb;
  logic [31:0]  last_wdata;

  task automatic check(input string name, input logic [156:0] act, input logic [156:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit misaligned(instr_t i);
    return (i.size == 2'd1 && i.exe[0]) || (i.size == 2'd2 && i.exe[1:0] != 2'd0);
  endfunction

  function automatic bit prior(instr_t i);
    return i.ferr || i.ires || i.ovf || i.sys || i.brk;
  endfunction

  function automatic bit issues(instr_t i);
    return (i.is_load || i.is_store) && !misaligned(i) && !prior(i);
  endfunction

  function automatic logic [31:0] load_value(instr_t i);
    logic [31:0] w;
    logic [31:0] v;
    w = mem[i.exe[5:2]];
    if (i.size == 2'd0) begin
      v = (w >> (8 * int'(i.exe[1:0]))) & 32'hFF;
      if (!i.lu && v[7]) v = v | 32'hFFFF_FF00;
    end else if (i.size == 2'd1) begin
      v = (w >> (16 * int'(i.exe[1]))) & 32'hFFFF;
      if (!i.lu && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [3:0] strobe_of(instr_t i);
    if (i.size == 2'd0) return 4'b0001 << i.exe[1:0];
    if (i.size == 2'd1) return i.exe[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] wdata_of(instr_t i);
    if (i.size == 2'd0) return {4{i.sdata[7:0]}};
    if (i.size == 2'd1) return {2{i.sdata[15:0]}};
    return i.sdata;
  endfunction

  function automatic logic [159:0] pack(instr_t i);
    return {i.is_load, i.is_store, i.size, i.lu, i.sdata, i.wen, i.wdest, i.exe, i.lo,
            i.f6, i.cp0, i.sys, i.eret, i.brk, i.ferr, i.ires, i.ovf, i.ds, i.pc};
  endfunction

  function automatic logic [156:0] expect_bus(instr_t i);
    logic [31:0] res;
    bit ra, wa;
    res = (i.is_load && issues(i)) ? load_value(i) : i.exe;
    ra  = i.is_load  && misaligned(i) && !prior(i);
    wa  = i.is_store && misaligned(i) && !prior(i);
    return {i.wen, i.wdest, res, i.lo, i.f6, i.cp0, i.sys, i.eret, i.brk, i.ferr, i.ires,
            ra, wa, i.ovf, i.exe, i.ds, i.pc};
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    int op;
    op         = int'($urandom_range(0, 2));
    i.is_load  = (op == 1);
    i.is_store = (op == 2);
    i.size     = 2'($urandom_range(0, 2));
    i.lu       = 1'($urandom_range(0, 1));
    i.sdata    = $urandom;
    i.wen      = 1'($urandom_range(0, 1));
    i.wdest    = 5'($urandom_range(0, 31));
    i.exe      = (op == 0) ? $urandom : 32'h1000 + $urandom_range(0, 63);
    i.lo       = $urandom;
    i.f6       = 6'($urandom_range(0, 63));
    i.cp0      = 8'($urandom_range(0, 255));
    i.sys      = ($urandom_range(0, 15) == 0);
    i.eret     = 1'($urandom_range(0, 1));
    i.brk      = ($urandom_range(0, 15) == 0);
    i.ferr     = ($urandom_range(0, 15) == 0);
    i.ires     = ($urandom_range(0, 15) == 0);
    i.ovf      = ($urandom_range(0, 15) == 0);
    i.ds       = 1'($urandom_range(0, 1));
    i.pc       = $urandom;
    return i;
  endfunction

  function automatic instr_t mk(bit ld, bit st, bit [1:0] sz, bit lu, logic [31:0] sd, logic [31:0] addr);
    instr_t i;
    i          = rand_instr();
    i.is_load  = ld;
    i.is_store = st;
    i.size     = sz;
    i.lu       = lu;
    i.sdata    = sd;
    i.exe      = addr;
    i.sys      = 1'b0;
    i.brk      = 1'b0;
    i.ferr     = 1'b0;
    i.ires     = 1'b0;
    i.ovf      = 1'b0;
    return i;
  endfunction

  task automatic present(input instr_t i);
    EXE_MEM_bus_r = pack(i);
    MEM_valid     = 1'b1;
    exp_wr        = i.is_store;
    exp_addr      = i.exe;
    exp_wstrb     = strobe_of(i);
    exp_wdata     = wdata_of(i);
  endtask

  // ---------------- memory responder ----------------
  initial begin
    dm_ack   = 1'b0;
    dm_rdata = '0;
    forever begin
      @(negedge clk);
      dm_ack   = 1'b0;
      dm_rdata = $urandom;
      if (reset) begin
        busy = 1'b0;
      end else if (dm_req) begin
        if (!busy) begin
          busy     = 1'b1;
          lat      = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
          last_lat = lat;
        end
        if (lat == 0) begin
          dm_ack = 1'b1;
          busy   = 1'b0;
          check("ack_wr", 157'(dm_wr), 157'(exp_wr));
          check("ack_addr", 157'(dm_addr), 157'(exp_addr));
          if (exp_wr) begin
            check("ack_wstrb", 157'(dm_wstrb), 157'(exp_wstrb));
            check("ack_wdata", 157'(dm_wdata), 157'(exp_wdata));
            last_wr    = dm_wr;
            last_wstrb = dm_wstrb;
            last_wdata = dm_wdata;
            for (int b = 0; b < 4; b++)
              if (exp_wstrb[b]) mem[exp_addr[5:2]][8*b +: 8] = exp_wdata[8*b +: 8];
          end else begin
            dm_rdata = mem[exp_addr[5:2]];
          end
        end else begin
          lat--;
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && MEM_over && WB_allow_in) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_transfer: got %h, expected no transfer", MEM_WB_bus);
        end else begin
          check("wb_bus", MEM_WB_bus, sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Presents one instruction and waits for its transfer to WB.
  task automatic run_instr(input instr_t i, input bit rand_wb,
                           output int req_cycles, output logic [156:0] xfer_bus);
    int c          = 0;
    int first_over = -1;
    bit done       = 1'b0;
    bit iss;
    iss        = issues(i);
    req_cycles = 0;
    xfer_bus   = '0;
    sb_q.push_back(expect_bus(i));
    @(posedge clk); #1;
    present(i);
    while (!done && c < 60) begin
      WB_allow_in = rand_wb ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (c == 0) begin
        check("req_at_issue", 157'(dm_req), 157'(iss));
        check("mem_wdest", 157'(MEM_wdest), 157'(i.wdest));
        check("mem_pc", 157'(MEM_pc), 157'(i.pc));
      end
      if (dm_req) req_cycles++;
      if (MEM_over && first_over < 0) first_over = c;
      if (MEM_over && WB_allow_in) begin
        done     = 1'b1;
        xfer_bus = MEM_WB_bus;
      end else begin
        @(posedge clk); #1;
        c++;
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL transfer_timeout: got no transfer in 60 cycles, expected one");
      void'(sb_q.pop_back());
    end
    check("over_latency", 157'(first_over), 157'(iss ? last_lat + 1 : 0));
    @(posedge clk); #1;
    MEM_valid   = 1'b0;
    WB_allow_in = 1'b0;
  endtask

  initial begin
    instr_t       i;
    int           rc;
    logic [156:0] xb;
    logic [31:0]  hold_res;

    for (int k = 0; k < 16; k++) mem[k] = $urandom;
    reset         = 1'b1;
    cancel        = 1'b0;
    WB_allow_in   = 1'b1;
    force_lat     = 0;
    i             = mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h1000);
    present(i);

    // Reset holds the request and result outputs low.
    @(negedge clk);
    check("reset_req", 157'(dm_req), 157'(0));
    check("reset_over", 157'(MEM_over), 157'(0));
    @(posedge clk); #1;
    reset     = 1'b0;
    MEM_valid = 1'b0;
    @(negedge clk);
    check("post_reset_req", 157'(dm_req), 157'(0));
    check("post_reset_over", 157'(MEM_over), 157'(0));
    check("post_reset_wdest", 157'(MEM_wdest), 157'(0));

    // ALU result passes through in the same cycle.
    run_instr(mk(1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h1234_5678), 1'b0, rc, xb);
    check("add_req_cycles", 157'(rc), 157'(0));
    check("add_result", 157'(xb[150:119]), 157'(32'h1234_5678));

    // Byte loads, ack after two wait cycles.
    mem[0]    = 32'h80FF_FFFF;
    force_lat = 2;
    run_instr(mk(1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 32'h1003), 1'b0, rc, xb);
    check("lb_req_cycles", 157'(rc), 157'(3));
    check("lb_result", 157'(xb[150:119]), 157'(32'hFFFF_FF80));
    run_instr(mk(1'b1, 1'b0, 2'd0, 1'b1, 32'h0, 32'h1003), 1'b0, rc, xb);
    check("lbu_result", 157'(xb[150:119]), 157'(32'h0000_0080));

    // Halfword store lane replication and strobes.
    force_lat = 1;
    run_instr(mk(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_BEEF, 32'h2002), 1'b0, rc, xb);
    check("sh_wr", 157'(last_wr), 157'(1));
    check("sh_wstrb", 157'(last_wstrb), 157'(4'b1100));
    check("sh_wdata", 157'(last_wdata), 157'(32'hBEEF_BEEF));

    // Misaligned accesses complete immediately with an address error.
    run_instr(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h1001), 1'b0, rc, xb);
    check("lw_mis_req", 157'(rc), 157'(0));
    check("lw_mis_raddr_err", 157'(xb[67]), 157'(1));
    check("lw_mis_addr", 157'(xb[64:33]), 157'(32'h1001));
    run_instr(mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h0, 32'h1002), 1'b0, rc, xb);
    check("sw_mis_waddr_err", 157'(xb[66]), 157'(1));
    check("sw_mis_raddr_err", 157'(xb[67]), 157'(0));

    // Cancel in WAIT: request persists until ack, result discarded.
    force_lat = 4;
    @(posedge clk); #1;
    present(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h1004));
    WB_allow_in = 1'b1;
    @(negedge clk);
    check("drain_req_c0", 157'(dm_req), 157'(1));
    @(posedge clk); #1;
    cancel = 1'b1;
    @(negedge clk);
    check("drain_req_c1", 157'(dm_req), 157'(1));
    check("drain_over_c1", 157'(MEM_over), 157'(0));
    @(posedge clk); #1;
    cancel        = 1'b0;
    MEM_valid     = 1'b0;
    EXE_MEM_bus_r = pack(rand_instr());
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      check("drain_req", 157'(dm_req), 157'(c <= 4));
      check("drain_over", 157'(MEM_over), 157'(0));
      if (c <= 4) check("drain_addr_stable", 157'(dm_addr), 157'(32'h1004));
      @(posedge clk); #1;
    end

    // Cancel and ack together in WAIT: straight back to IDLE.
    force_lat = 1;
    present(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h1008));
    @(negedge clk);
    @(posedge clk); #1;
    cancel = 1'b1;
    @(negedge clk);
    check("cancel_ack_over", 157'(MEM_over), 157'(0));
    @(posedge clk); #1;
    cancel    = 1'b0;
    MEM_valid = 1'b0;
    @(negedge clk);
    check("cancel_ack_req_after", 157'(dm_req), 157'(0));
    run_instr(mk(1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'hCAFE_0001), 1'b0, rc, xb);

    // WB back-pressure in HOLD: result stays steady until accepted.
    force_lat = 0;
    i         = mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h100C);
    xb        = expect_bus(i);
    hold_res  = xb[150:119];
    sb_q.push_back(xb);
    @(posedge clk); #1;
    present(i);
    WB_allow_in = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      WB_allow_in = (c == 5);
      @(negedge clk);
      check("hold_over", 157'(MEM_over), 157'(1));
      check("hold_result", 157'(MEM_WB_bus[150:119]), 157'(hold_res));
    end
    @(posedge clk); #1;
    MEM_valid   = 1'b0;
    WB_allow_in = 1'b0;
    @(negedge clk);
    check("hold_after_over", 157'(MEM_over), 157'(0));
    check("hold_after_req", 157'(dm_req), 157'(0));

    // Cancel beats WB_allow_in in HOLD.
    @(posedge clk); #1;
    present(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h1010));
    @(negedge clk);
    @(posedge clk); #1;
    cancel      = 1'b1;
    WB_allow_in = 1'b1;
    @(negedge clk);
    check("hold_cancel_over", 157'(MEM_over), 157'(0));
    @(posedge clk); #1;
    cancel      = 1'b0;
    MEM_valid   = 1'b0;
    WB_allow_in = 1'b0;
    @(negedge clk);
    check("hold_cancel_after_over", 157'(MEM_over), 157'(0));
    check("hold_cancel_after_req", 157'(dm_req), 157'(0));

    // Reset during WAIT abandons the request.
    force_lat = 10;
    @(posedge clk); #1;
    present(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h1014));
    @(negedge clk);
    check("rst_wait_req_before", 157'(dm_req), 157'(1));
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_wait_req", 157'(dm_req), 157'(0));
    check("rst_wait_over", 157'(MEM_over), 157'(0));
    @(posedge clk); #1;
    reset     = 1'b0;
    MEM_valid = 1'b0;
    @(negedge clk);
    check("rst_wait_req_after", 157'(dm_req), 157'(0));
    force_lat = -1;
    run_instr(mk(1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0BAD_F00D), 1'b0, rc, xb);

    // Randomized traffic with random ack latency and WB back-pressure.
    for (int n = 0; n < 200; n++) run_instr(rand_instr(), 1'b1, rc, xb);

    @(posedge clk); #1;
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
